// File: rtl/uart_lite.sv
// uart_lite: 8N1 Wishbone UART peripheral with a programmable 16-bit baud divisor.
// Registers: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV_L, 4 DIV_H, 5-7 read as zero.
// Optional feature macro: UART_RXFIFO_EN. When defined, RX storage is a 4-entry FIFO.
// When it is undefined, RX storage is a single holding register.
module uart_lite #(
  parameter logic [15:0] DIV_RST = 16'd433
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] WB_ADRi,
  input  logic [7:0] WB_DATi,
  output logic [7:0] WB_DATo,
  input  logic       WB_WEi,
  input  logic       WB_CYCi,
  input  logic       WB_STBi,
  output logic       WB_ACKo,
  output logic       TXD,
  input  logic       RXD,
  output logic       UART_INT
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus / register signals ----------------
  logic        ack_q, ack_d;
  logic [7:0]  dat_q, dat_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        int_q, int_d;
  logic        bus_fire, wr_fire, rd_fire;
  logic        tx_wr, rx_pop, status_wr;
  logic [7:0]  rdata;

  // ---------------- transmitter signals ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        txd_q, txd_d;
  logic        tx_load;
  logic        tx_bit_end;

  // ---------------- receiver signals ----------------
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done_q, rx_done_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_ferr_set;

  // ---------------- RX storage common view ----------------
  logic        rx_avail;
  logic [7:0]  rx_rdata;
  logic        rx_pop_ok;
  logic        rx_push_ok;
  logic        rx_overrun_set;

  // A request is taken on the edge that raises the ack; holding ack off for one
  // cycle afterwards gives exactly one ack per request.
  assign bus_fire  = WB_CYCi & WB_STBi & ~ack_q;
  assign wr_fire   = bus_fire & WB_WEi;
  assign rd_fire   = bus_fire & ~WB_WEi;
  assign tx_wr     = wr_fire & (WB_ADRi == 3'd0) & ~hold_full_q;
  assign rx_pop    = rd_fire & (WB_ADRi == 3'd0);
  assign status_wr = wr_fire & (WB_ADRi == 3'd1);

  // Read data mux, sampled into the registered read bus on the acking edge
  always_comb begin
    rdata = 8'h00;
    case (WB_ADRi)
      3'd0:    rdata = rx_rdata;
      3'd1:    rdata = {3'b000, ferr_q, ovr_q, (tx_state_q != TX_IDLE), ~hold_full_q, rx_avail};
      3'd2:    rdata = {5'b00000, ctrl_q};
      3'd3:    rdata = div_q[7:0];
      3'd4:    rdata = div_q[15:8];
      default: rdata = 8'h00;
    endcase
  end

  // Next-state for ack, read data, control/divisor registers, sticky flags and the interrupt
  always_comb begin
    ack_d  = bus_fire;
    dat_d  = dat_q;
    ctrl_d = ctrl_q;
    div_d  = div_q;
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (rd_fire) begin
      dat_d = rdata;
    end
    if (wr_fire) begin
      case (WB_ADRi)
        3'd2:    ctrl_d = WB_DATi[2:0];
        3'd3:    div_d  = {div_q[15:8], WB_DATi};
        3'd4:    div_d  = {WB_DATi, div_q[7:0]};
        default: ;
      endcase
    end
    // Clear-by-write first, then a new event in the same cycle wins so it is never lost
    if (status_wr && WB_DATi[3]) ovr_d  = 1'b0;
    if (status_wr && WB_DATi[4]) ferr_d = 1'b0;
    if (rx_overrun_set)          ovr_d  = 1'b1;
    if (rx_ferr_set)             ferr_d = 1'b1;
    int_d = (rx_avail & ctrl_q[0]) | (~hold_full_q & ctrl_q[1]) | ((ovr_q | ferr_q) & ctrl_q[2]);
  end

  // Bus-side register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q  <= 1'b0;
      dat_q  <= 8'h00;
      ctrl_q <= 3'b000;
      div_q  <= DIV_RST;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      int_q  <= int_d;
    end
  end

  assign tx_bit_end = (tx_cnt_q == tx_div_q);

  // Transmit engine next-state; TXD is a registered copy of the current state,
  // so the line lags the state by one clock uniformly and frames stay gap-free.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_load     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (hold_full_q) tx_load = 1'b1;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d   = 16'd0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = 16'd0;
          if (hold_full_q) tx_load    = 1'b1;
          else             tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Frame start: take the byte and latch the divisor for the whole frame
    if (tx_load) begin
      tx_state_d  = TX_START;
      tx_cnt_d    = 16'd0;
      tx_shift_d  = hold_q;
      tx_div_d    = div_q;
      hold_full_d = 1'b0;
    end
    // Only accepted while the holding register is empty, so never collides with a load
    if (tx_wr) begin
      hold_d      = WB_DATi;
      hold_full_d = 1'b1;
    end
    case (tx_state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // Transmit engine state; reset drives TXD high without waiting for a clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= DIV_RST;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
    end
  end

  // Receive engine next-state: start-bit check at half a bit, then full-bit sampling
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_done_d   = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = 16'd0;
          rx_div_d   = div_q;
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1)) begin
          rx_cnt_d = 16'd0;
          rx_bit_d = 3'd0;
          // A line that is high again at mid-start was a glitch, not a frame
          if (rx_s2_q) rx_state_d = RX_IDLE;
          else         rx_state_d = RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == rx_div_q) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            rx_done_d = 1'b1;
            rx_byte_d = rx_shift_q;
          end else begin
            rx_ferr_set = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive synchronizer, edge history and engine state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= DIV_RST;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_done_q  <= 1'b0;
      rx_byte_q  <= 8'h00;
    end else begin
      rx_s1_q    <= RXD;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_done_q  <= rx_done_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

`ifdef UART_RXFIFO_EN
  logic [7:0] rx_fifo_mem [0:3];
  logic [1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [2:0] rx_count_q, rx_count_d;

  assign rx_avail       = (rx_count_q != 3'd0);
  assign rx_rdata       = rx_fifo_mem[rx_rd_ptr_q];
  assign rx_pop_ok      = rx_pop & rx_avail;
  // A pop in the same cycle frees the slot the new byte needs
  assign rx_push_ok     = rx_done_q & ((rx_count_q != 3'd4) | rx_pop_ok);
  assign rx_overrun_set = rx_done_q & (rx_count_q == 3'd4) & ~rx_pop_ok;

  // FIFO pointer and occupancy next-state
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push_ok) rx_wr_ptr_d = rx_wr_ptr_q + 2'd1;
    if (rx_pop_ok)  rx_rd_ptr_d = rx_rd_ptr_q + 2'd1;
    if (rx_push_ok && !rx_pop_ok)      rx_count_d = rx_count_q + 3'd1;
    else if (!rx_push_ok && rx_pop_ok) rx_count_d = rx_count_q - 3'd1;
  end

  // FIFO pointer and occupancy state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr_q <= 2'd0;
      rx_rd_ptr_q <= 2'd0;
      rx_count_q  <= 3'd0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
    end
  end

  // FIFO storage array, written only; contents need no reset
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_fifo_mem[rx_wr_ptr_q] <= rx_byte_q;
  end
`else
  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rx_full_q, rx_full_d;

  assign rx_avail       = rx_full_q;
  assign rx_rdata       = rx_buf_q;
  assign rx_pop_ok      = rx_pop & rx_full_q;
  assign rx_push_ok     = rx_done_q & (~rx_full_q | rx_pop_ok);
  assign rx_overrun_set = rx_done_q & rx_full_q & ~rx_pop_ok;

  // Single holding register next-state; a simultaneous pop and push keeps it full
  always_comb begin
    rx_buf_d  = rx_buf_q;
    rx_full_d = rx_full_q;
    if (rx_pop_ok) rx_full_d = 1'b0;
    if (rx_push_ok) begin
      rx_buf_d  = rx_byte_q;
      rx_full_d = 1'b1;
    end
  end

  // Single holding register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf_q  <= 8'h00;
      rx_full_q <= 1'b0;
    end else begin
      rx_buf_q  <= rx_buf_d;
      rx_full_q <= rx_full_d;
    end
  end
`endif

  assign WB_ACKo  = ack_q;
  assign WB_DATo  = dat_q;
  assign TXD      = txd_q;
  assign UART_INT = int_q;

endmodule

// File: tb/tb_uart_lite.sv
// Testbench for uart_lite: directed bus transactions with a read-data scoreboard,
// plus direct line/interrupt checks. Follows UART_RXFIFO_EN like the design.
module tb_uart_lite;

  logic       clk;
  logic       rst;
  logic [2:0] adr;
  logic [7:0] dati;
  logic [7:0] dato;
  logic       we, cyc, stb, ack;
  logic       txd, rxd, uart_int;
  logic       loop_en, rxd_drv;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         chk;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t new_e;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_lite dut (
    .clk      (clk),
    .rst      (rst),
    .WB_ADRi  (adr),
    .WB_DATi  (dati),
    .WB_DATo  (dato),
    .WB_WEi   (we),
    .WB_CYCi  (cyc),
    .WB_STBi  (stb),
    .WB_ACKo  (ack),
    .TXD      (txd),
    .RXD      (rxd),
    .UART_INT (uart_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every ack pops one expected entry; reads are compared
  always @(negedge clk) begin
    if (ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack got=%02h required=none", dato);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) begin
          checks++;
          if (dato !== mon_e.val) begin
            errors++;
            $display("FAIL %s got=%02h required=%02h", mon_e.name, dato, mon_e.val);
          end else begin
            $display("ok   %s read=%02h", mon_e.name, dato);
          end
        end else begin
          $display("ok   %s write acked", mon_e.name);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%02h required=%02h", name, got, req);
    end else begin
      $display("ok   %s value=%02h", name, got);
    end
  endtask

  task automatic wb_xfer(input logic [2:0] a, input logic [7:0] d, input logic w,
                         input bit c, input logic [7:0] e, input string name);
    bit got;
    new_e.chk  = c;
    new_e.val  = e;
    new_e.name = name;
    sb_q.push_back(new_e);
    @(negedge clk);
    adr = a; dati = d; we = w; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout got=0 required=1", name);
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string name);
    wb_xfer(a, 8'h00, 1'b1 ^ 1'b1, 1'b1, e, name);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input string name);
    wb_xfer(a, d, 1'b1, 1'b0, 8'h00, name);
  endtask

  // Called right after the DATA-write returns (1 time unit past the ack edge), DIV=7
  task automatic check_tx_frame(input logic [7:0] b, input string tag);
    chk({tag, "_txd_at_ack"}, {7'd0, txd}, 8'h01);
    @(posedge clk); #1;
    chk({tag, "_txd_ack+1"}, {7'd0, txd}, 8'h01);
    @(posedge clk); #1;
    chk({tag, "_txd_fall_ack+2"}, {7'd0, txd}, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_start_mid"}, {7'd0, txd}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge clk);
      #1;
      chk($sformatf("%s_bit%0d", tag, i), {7'd0, txd}, {7'd0, b[i]});
    end
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_stop_mid"}, {7'd0, txd}, 8'h01);
    rd(3'd1, 8'h06, {tag, "_status_in_stop"});
    repeat (5) @(posedge clk);
    rd(3'd1, 8'h02, {tag, "_status_after_stop"});
  endtask

  // Drives one 8N1 frame on RXD at 8 clocks per bit (DIV=7)
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (8) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (8) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1'b0; adr = 3'd0; dati = 8'h00; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    loop_en = 1'b0; rxd_drv = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {7'd0, txd}, 8'h01);
    chk("rst_int", {7'd0, uart_int}, 8'h00);
    chk("rst_ack", {7'd0, ack}, 8'h00);
    chk("rst_dato", dato, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rd(3'd1, 8'h02, "status_reset");
    rd(3'd3, 8'hB1, "div_l_reset");
    rd(3'd4, 8'h01, "div_h_reset");
    rd(3'd2, 8'h00, "ctrl_reset");
    wr(3'd5, 8'hFF, "wr_reg5");
    rd(3'd5, 8'h00, "reg5_zero");

    // Transmit 0xA5 at DIV=7
    wr(3'd3, 8'h07, "wr_div_l");
    wr(3'd4, 8'h00, "wr_div_h");
    rd(3'd3, 8'h07, "div_l_readback");
    wr(3'd0, 8'hA5, "wr_data_a5");
    check_tx_frame(8'hA5, "tx_a5");

    // Loopback receive of 0x3C with IE_RX
    wr(3'd2, 8'h01, "wr_ctrl_ie_rx");
    loop_en = 1'b1;
    wr(3'd0, 8'h3C, "wr_data_3c");
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (uart_int) begin
        seen = 1'b1;
        break;
      end
    end
    chk("loop_int_rise", {7'd0, seen}, 8'h01);
    repeat (20) @(posedge clk);
    rd(3'd1, 8'h03, "loop_status_avail");
    rd(3'd0, 8'h3C, "loop_data");
    repeat (2) @(posedge clk);
    #1;
    chk("loop_int_clear", {7'd0, uart_int}, 8'h00);
    rd(3'd1, 8'h02, "loop_status_empty");
    loop_en = 1'b0;

    // Framing error with IE_ERR, then write-1-to-clear
    wr(3'd2, 8'h04, "wr_ctrl_ie_err");
    send_frame(8'h55, 1'b0);
    chk("ferr_int", {7'd0, uart_int}, 8'h01);
    rd(3'd1, 8'h12, "ferr_status");
    wr(3'd1, 8'h10, "w1c_ferr");
    rd(3'd1, 8'h02, "ferr_cleared");
    repeat (2) @(posedge clk);
    #1;
    chk("ferr_int_clear", {7'd0, uart_int}, 8'h00);
    wr(3'd2, 8'h00, "wr_ctrl_off");

    // Overrun
`ifdef UART_RXFIFO_EN
    for (int i = 0; i < 5; i++) send_frame(8'h11 * (i + 1), 1'b1);
    rd(3'd1, 8'h0B, "ovr_status");
    rd(3'd0, 8'h11, "fifo_data0");
    rd(3'd0, 8'h22, "fifo_data1");
    rd(3'd0, 8'h33, "fifo_data2");
    rd(3'd0, 8'h44, "fifo_data3");
`else
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rd(3'd1, 8'h0B, "ovr_status");
    rd(3'd0, 8'h11, "ovr_data_first");
`endif
    rd(3'd1, 8'h0A, "ovr_status_drained");
    wr(3'd1, 8'h08, "w1c_ovr");
    rd(3'd1, 8'h02, "ovr_cleared");

    // Reset in the middle of a transmit frame
    wr(3'd0, 8'h00, "wr_data_00");
    repeat (30) @(posedge clk);
    #1;
    chk("midframe_txd_low", {7'd0, txd}, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_txd_high", {7'd0, txd}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rd(3'd1, 8'h02, "post_rst_status");
    rd(3'd3, 8'hB1, "post_rst_div_l");
    rd(3'd2, 8'h00, "post_rst_ctrl");
    wr(3'd3, 8'h07, "wr_div_l2");
    wr(3'd4, 8'h00, "wr_div_h2");
    wr(3'd0, 8'h5A, "wr_data_5a");
    check_tx_frame(8'h5A, "tx_5a");

    repeat (4) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
